bist_march_ctrl: RTL and testbench
==================================

Name: bist_march_ctrl

Overview:
- March C- sequencer for the 64x8 single-port BIST SRAM.
- Generates chip-select, read/write, address and write data, and compares read data against expected values.
- Reports done, sticky fail and first-failure diagnostics.
- Sits behind the normal/BIST mux. When opr=1, the mux routes the mem_* outputs of this block to the RAM.

Parameters:
- ADDR_W, 6, address width; depth = 2**ADDR_W.
- DATA_W, 8, word width; must be a power of 2.
- STOP_ON_FAIL, 0, when 1 the run aborts to DONE on the first mismatch.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  level, sampled each edge; launches a run from IDLE or DONE.
- mem_rdata  in  DATA_W  RAM dataout; combinational read, valid in the same cycle as a read command.
- mem_cs  out  1  RAM chip select (csin).
- mem_rwbar  out  1  1 = read, 0 = write (rwbarin).
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM datain.
- busy  out  1  high while the march runs.
- done  out  1  high in DONE; held until the next start.
- fail  out  1  sticky mismatch flag; cleared on start.
- fail_addr  out  ADDR_W  address of the first mismatch.
- fail_elem  out  3  march element (0-5) of the first mismatch.
- fail_bg  out  2  background index of the first mismatch.
- fail_exp  out  DATA_W  expected word at the first mismatch.
- fail_act  out  DATA_W  read word at the first mismatch.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0: mem_cs, mem_rwbar, mem_addr, mem_wdata, busy, done, fail, and all fail_* outputs.
  - Reset mid-run aborts immediately; no further RAM access occurs.
- States are IDLE, RUN and DONE.
  - IDLE/DONE -> RUN on start=1. This clears fail and all fail_* outputs, sets element=0, bg=0, addr=0, op=0.
  - start is ignored while in RUN.
- Backgrounds: bg k in 0..log2(DATA_W).
  - For DATA_W=8: B0=00, B1=55, B2=33, B3=0F.
  - D0 = Bk and D1 = ~Bk.
- March C- elements, run per background:
  - E0 up(w D0)
  - E1 up(r D0, w D1)
  - E2 up(r D1, w D0)
  - E3 down(r D0, w D1)
  - E4 down(r D1, w D0)
  - E5 up(r D0)
- Address order: up is 0 to 2**ADDR_W-1; down is 2**ADDR_W-1 to 0.
- One RAM operation per cycle, registered outputs.
  - mem_cs=1 on every RUN cycle.
  - Two-op elements do r then w at the same address, then advance.
- Cycle counts:
  - Per background: 10*2**ADDR_W cycles (640 at default).
  - Total: 2560 cycles at default.
  - The start edge is E0. RAM ops occupy cycles 1..2560.
  - At edge 2561: busy=0, done=1, mem_cs=0.
- Compare: on each read cycle, mem_rdata is sampled at the closing edge and compared to the expected word.
  - On mismatch: fail=1 from the next cycle.
  - fail_* captures only if fail was 0 (first failure wins).
- STOP_ON_FAIL=1: the mismatch edge goes directly to DONE (busy=0, done=1).
- Address counter wrap ends the element. The last element of the last background transitions to DONE.
- mem_addr and mem_wdata hold their last value when idle. Only mem_cs gates the RAM.

Test Plan:
- Fault-free RAM model: pulse start for 1 cycle -> busy for exactly 2560 cycles, then done=1, fail=0, mem_cs=0 from cycle 2561.
- addr 5 bit0 stuck-at-1 -> fail rises at cycle 76 with fail_addr=5, fail_elem=1, fail_bg=0, fail_exp=00, fail_act=01. The run continues to cycle 2560 and fail_* stays unchanged.
- Same fault with STOP_ON_FAIL=1 -> done=1 and busy=0 at cycle 76; no RAM accesses after cycle 75.
- start held high throughout the run -> no restart; done at 2561. The following cycle (start still 1) restarts the run and clears fail.
- rst asserted at cycle 300 -> all outputs 0 at the next edge, state IDLE. A fresh start runs the full 2560 cycles.
- Check the RAM op trace: cycles 641-704 are writes of 55 to addresses 0..63. Cycle 705 is a read at address 0 expecting 55.

Source files
------------

// File: rtl/bist_march_ctrl.sv
// bist_march_ctrl
//   March C- sequencer for the 64x8 single-port BIST SRAM. Walks every data
//   background through the six March C- elements, drives one registered RAM
//   operation per cycle and checks every read against the expected word.
//
//   Parameters
//     ADDR_W        address width, depth = 2**ADDR_W
//     DATA_W        word width, power of 2 (up to 8, four backgrounds)
//     STOP_ON_FAIL  1 = abort to DONE on the first mismatch
//
//   Ports
//     clk, rst      rising-edge clock, synchronous active-high reset
//     start         level; launches a run from IDLE or DONE
//     mem_rdata     combinational RAM read data for the op on the bus
//     mem_cs        RAM chip select, high on every RUN cycle
//     mem_rwbar     1 = read, 0 = write
//     mem_addr      RAM address
//     mem_wdata     RAM write data
//     busy, done    run status; done holds until the next start
//     fail          sticky mismatch flag, cleared on start
//     fail_addr/elem/bg/exp/act  diagnostics of the first mismatch
module bist_march_ctrl #(
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 8,
    parameter int STOP_ON_FAIL = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_cs,
    output logic              mem_rwbar,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              fail,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    output logic [1:0]        fail_bg,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_act
);

    localparam int                NBG      = $clog2(DATA_W) + 1;
    localparam logic [1:0]        LAST_BG  = 2'(NBG - 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Background k: k=0 is all zeros, otherwise alternating runs of
    // 2**(k-1) ones and zeros starting with ones at bit 0 (55, 33, 0F).
    function automatic logic [DATA_W-1:0] bg_word(input logic [1:0] k);
        logic [DATA_W-1:0] w;
        w = '0;
        if (k != 2'd0) begin
            for (int i = 0; i < DATA_W; i++) begin
                w[i] = (((i >> (int'(k) - 1)) & 1) == 0);
            end
        end
        return w;
    endfunction

    logic [1:0]        state;

    // Issue-stage counters: the operation to be placed on the bus next.
    logic [2:0]        elem_p0;
    logic [1:0]        bg_p0;
    logic [ADDR_W-1:0] addr_p0;
    logic              phase_p0;   // 0 = first op of element, 1 = second (write)
    logic              fin;        // final operation has been issued

    // Bus-stage copies of the operation currently on the RAM pins.
    logic [DATA_W-1:0] exp_p1;
    logic [2:0]        elem_p1;
    logic [1:0]        bg_p1;

    logic [DATA_W-1:0] d0;
    logic              two_op;
    logic              down;
    logic              is_read;
    logic [DATA_W-1:0] op_data;
    logic              at_end;
    logic              elem_end;
    logic              last_op;
    logic [2:0]        nxt_elem;
    logic [1:0]        nxt_bg;
    logic [ADDR_W-1:0] nxt_addr;
    logic              nxt_phase;
    logic              rd_check;
    logic              mismatch;
    logic              stop_now;
    logic              issue;

    always_comb begin
        d0      = bg_word(bg_p0);
        two_op  = (elem_p0 >= 3'd1) && (elem_p0 <= 3'd4);
        down    = (elem_p0 == 3'd3) || (elem_p0 == 3'd4);
        is_read = (elem_p0 == 3'd5) || (two_op && !phase_p0);

        // Reads in E2/E4 expect D1; writes in E1/E3 store D1.
        if (is_read) begin
            op_data = ((elem_p0 == 3'd2) || (elem_p0 == 3'd4)) ? ~d0 : d0;
        end else begin
            op_data = ((elem_p0 == 3'd1) || (elem_p0 == 3'd3)) ? ~d0 : d0;
        end

        at_end   = down ? (addr_p0 == '0) : (addr_p0 == ADDR_MAX);
        elem_end = at_end && !(two_op && !phase_p0);
        last_op  = elem_end && (elem_p0 == 3'd5) && (bg_p0 == LAST_BG);

        nxt_phase = 1'b0;
        nxt_addr  = addr_p0;
        nxt_elem  = elem_p0;
        nxt_bg    = bg_p0;
        if (two_op && !phase_p0) begin
            nxt_phase = 1'b1;
        end else if (!at_end) begin
            nxt_addr = down ? (addr_p0 - 1'b1) : (addr_p0 + 1'b1);
        end else if (elem_p0 == 3'd5) begin
            nxt_elem = 3'd0;
            nxt_bg   = bg_p0 + 2'd1;
            nxt_addr = '0;
        end else begin
            nxt_elem = elem_p0 + 3'd1;
            // E3 and E4 run downward, so they start from the top address.
            nxt_addr = ((elem_p0 == 3'd2) || (elem_p0 == 3'd3)) ? ADDR_MAX : '0;
        end

        // A read on the bus closes at this edge; mem_rdata is valid now.
        rd_check = mem_cs && mem_rwbar;
        mismatch = rd_check && (mem_rdata != exp_p1);
        stop_now = mismatch && (STOP_ON_FAIL != 0);
        issue    = (state == S_RUN) && !fin && !stop_now;
    end

    // ---- p0 -> p1: control, RAM pins and diagnostics ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            elem_p0   <= 3'd0;
            bg_p0     <= 2'd0;
            addr_p0   <= '0;
            phase_p0  <= 1'b0;
            fin       <= 1'b0;
            mem_cs    <= 1'b0;
            mem_rwbar <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            fail_addr <= '0;
            fail_elem <= 3'd0;
            fail_bg   <= 2'd0;
            fail_exp  <= '0;
            fail_act  <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RUN;
                        done      <= 1'b0;
                        fail      <= 1'b0;
                        fail_addr <= '0;
                        fail_elem <= 3'd0;
                        fail_bg   <= 2'd0;
                        fail_exp  <= '0;
                        fail_act  <= '0;
                        elem_p0   <= 3'd0;
                        bg_p0     <= 2'd0;
                        addr_p0   <= '0;
                        phase_p0  <= 1'b0;
                        fin       <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (mismatch) begin
                        fail <= 1'b1;
                        if (!fail) begin
                            fail_addr <= mem_addr;
                            fail_elem <= elem_p1;
                            fail_bg   <= bg_p1;
                            fail_exp  <= exp_p1;
                            fail_act  <= mem_rdata;
                        end
                    end
                    if (stop_now || fin) begin
                        state  <= S_DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        mem_cs <= 1'b0;
                    end else begin
                        mem_cs    <= 1'b1;
                        mem_rwbar <= is_read;
                        mem_addr  <= addr_p0;
                        mem_wdata <= op_data;
                        busy      <= 1'b1;
                        elem_p0   <= nxt_elem;
                        bg_p0     <= nxt_bg;
                        addr_p0   <= nxt_addr;
                        phase_p0  <= nxt_phase;
                        fin       <= last_op;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // ---- p0 -> p1: expected word and tags for the op on the bus ----
    always_ff @(posedge clk) begin
        if (issue) begin
            exp_p1  <= op_data;
            elem_p1 <= elem_p0;
            bg_p1   <= bg_p0;
        end
    end

endmodule

// File: tb/tb_bist_march_ctrl.sv
module tb_bist_march_ctrl;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int DEPTH = 64;
    localparam int NOPS  = 2560;

    logic clk = 1'b0;
    logic rst;
    logic start;
    always #5 clk = ~clk;

    // DUT a: continue on fail; DUT b: stop on fail. Both see the same fault.
    logic [DW-1:0] rdata_a, rdata_b;
    logic          cs_a, rw_a, busy_a, done_a, fail_a;
    logic          cs_b, rw_b, busy_b, done_b, fail_b;
    logic [AW-1:0] addr_a, addr_b, faddr_a, faddr_b;
    logic [DW-1:0] wdata_a, wdata_b, fexp_a, fexp_b, fact_a, fact_b;
    logic [2:0]    felem_a, felem_b;
    logic [1:0]    fbg_a, fbg_b;

    bist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STOP_ON_FAIL(0)) dut (
        .clk(clk), .rst(rst), .start(start), .mem_rdata(rdata_a),
        .mem_cs(cs_a), .mem_rwbar(rw_a), .mem_addr(addr_a), .mem_wdata(wdata_a),
        .busy(busy_a), .done(done_a), .fail(fail_a), .fail_addr(faddr_a),
        .fail_elem(felem_a), .fail_bg(fbg_a), .fail_exp(fexp_a), .fail_act(fact_a));

    bist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .STOP_ON_FAIL(1)) dut_s (
        .clk(clk), .rst(rst), .start(start), .mem_rdata(rdata_b),
        .mem_cs(cs_b), .mem_rwbar(rw_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
        .busy(busy_b), .done(done_b), .fail(fail_b), .fail_addr(faddr_b),
        .fail_elem(felem_b), .fail_bg(fbg_b), .fail_exp(fexp_b), .fail_act(fact_b));

    // RAM models with an optional stuck-at bit on read.
    logic [DW-1:0] ram_a [DEPTH];
    logic [DW-1:0] ram_b [DEPTH];
    bit f_en = 0;
    int f_addr = 0, f_bit = 0;
    bit f_val = 0;

    always_comb begin
        rdata_a = ram_a[addr_a];
        if (f_en && int'(addr_a) == f_addr) rdata_a[f_bit] = f_val;
    end
    always_comb begin
        rdata_b = ram_b[addr_b];
        if (f_en && int'(addr_b) == f_addr) rdata_b[f_bit] = f_val;
    end
    always @(posedge clk) if (cs_a && !rw_a) ram_a[addr_a] <= wdata_a;
    always @(posedge clk) if (cs_b && !rw_b) ram_b[addr_b] <= wdata_b;

    // Reference op list built from the March C- element table.
    typedef struct {
        bit rd; int addr; logic [DW-1:0] data; int elem; int bg;
    } op_t;
    op_t ops[$];

    typedef struct {
        bit en; int a; int bt; bit v;
        int e_fail; int e_cyc; int e_elem; int e_bg; int e_exp; int e_act;
    } vec_t;
    vec_t vecs[4];

    int n_cmp = 0, n_err = 0;
    int busy_cnt, done_cyc_a, done_cyc_b, fcyc_a, trace_err, last_acc_b;
    int cs_at_done_a, busy_at_done_b;
    int p_fail, p_cyc, p_addr, p_elem, p_bg, p_exp, p_act;
    int x_fail, x_cyc, x_addr, x_elem, x_bg, x_exp, x_act;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    function automatic logic [DW-1:0] pattern(input int k);
        logic [DW-1:0] p;
        p = '0;
        if (k > 0)
            for (int i = 0; i < DW; i++) p[i] = ((i / (1 << (k - 1))) % 2 == 0);
        return p;
    endfunction

    task automatic push(input bit rd, input int a, input logic [DW-1:0] d,
                        input int e, input int b);
        op_t o;
        o.rd = rd; o.addr = a; o.data = d; o.elem = e; o.bg = b;
        ops.push_back(o);
    endtask

    task automatic build_ops();
        logic [DW-1:0] p;
        int a;
        for (int b = 0; b < 4; b++) begin
            p = pattern(b);
            for (int e = 0; e < 6; e++) begin
                for (int j = 0; j < DEPTH; j++) begin
                    a = (e == 3 || e == 4) ? DEPTH - 1 - j : j;
                    case (e)
                        0: push(0, a, p, e, b);
                        1, 3: begin push(1, a, p, e, b);  push(0, a, ~p, e, b); end
                        2, 4: begin push(1, a, ~p, e, b); push(0, a, p, e, b);  end
                        default: push(1, a, p, e, b);
                    endcase
                end
            end
        end
    endtask

    // Replays the op list against an abstract faulty memory.
    task automatic predict();
        logic [DW-1:0] m [DEPTH];
        logic [DW-1:0] v;
        p_fail = 0; p_cyc = 0; p_addr = 0; p_elem = 0; p_bg = 0; p_exp = 0; p_act = 0;
        for (int i = 0; i < DEPTH; i++) m[i] = '0;
        for (int i = 0; i < ops.size(); i++) begin
            if (!ops[i].rd) m[ops[i].addr] = ops[i].data;
            else begin
                v = m[ops[i].addr];
                if (f_en && ops[i].addr == f_addr) v[f_bit] = f_val;
                if (v != ops[i].data && p_fail == 0) begin
                    p_fail = 1; p_cyc = i + 2; p_addr = ops[i].addr;
                    p_elem = ops[i].elem; p_bg = ops[i].bg;
                    p_exp = int'(ops[i].data); p_act = int'(v);
                end
            end
        end
    endtask

    // Launches a run; edge 0 samples start, then samples cycle c at #1 after edge c.
    task automatic run_one(input bit hold, input bit spot);
        busy_cnt = 0; done_cyc_a = -1; done_cyc_b = -1; fcyc_a = -1;
        trace_err = 0; last_acc_b = -1; cs_at_done_a = -1; busy_at_done_b = -1;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        for (int c = 1; c <= 2700; c++) begin
            @(posedge clk); #1;
            if (c <= NOPS) begin
                if (!(cs_a && busy_a && rw_a == ops[c-1].rd && int'(addr_a) == ops[c-1].addr &&
                      (ops[c-1].rd || wdata_a == ops[c-1].data))) trace_err++;
            end
            if (spot && c == 641) begin
                chk("op641_rw", int'(rw_a), 0); chk("op641_addr", int'(addr_a), 0);
                chk("op641_wdata", int'(wdata_a), 'h55);
            end
            if (spot && c == 704) begin
                chk("op704_rw", int'(rw_a), 0); chk("op704_addr", int'(addr_a), 63);
                chk("op704_wdata", int'(wdata_a), 'h55);
            end
            if (spot && c == 705) begin
                chk("op705_rw", int'(rw_a), 1); chk("op705_addr", int'(addr_a), 0);
            end
            if (busy_a) busy_cnt++;
            if (fail_a && fcyc_a < 0) fcyc_a = c;
            if (done_a && done_cyc_a < 0) begin done_cyc_a = c; cs_at_done_a = int'(cs_a); end
            if (cs_b && done_cyc_b < 0) last_acc_b = c;
            if (done_b && done_cyc_b < 0) begin done_cyc_b = c; busy_at_done_b = int'(busy_b); end
            if (done_cyc_a >= 0 && (hold || done_cyc_b >= 0)) break;
        end
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_busy_cycles"}, busy_cnt, NOPS);
        chk({tag, "_done_cycle"}, done_cyc_a, NOPS + 1);
        chk({tag, "_cs_at_done"}, cs_at_done_a, 0);
        chk({tag, "_trace_errs"}, trace_err, 0);
        chk({tag, "_fail"}, int'(fail_a), x_fail);
        if (x_fail != 0) begin
            chk({tag, "_fail_cycle"}, fcyc_a, x_cyc);
            chk({tag, "_fail_addr"}, int'(faddr_a), x_addr);
            chk({tag, "_fail_elem"}, int'(felem_a), x_elem);
            chk({tag, "_fail_bg"}, int'(fbg_a), x_bg);
            chk({tag, "_fail_exp"}, int'(fexp_a), x_exp);
            chk({tag, "_fail_act"}, int'(fact_a), x_act);
        end
        chk({tag, "_stop_done_cycle"}, done_cyc_b, (x_fail != 0) ? x_cyc : NOPS + 1);
        chk({tag, "_stop_busy_at_done"}, busy_at_done_b, 0);
        chk({tag, "_stop_last_access"}, last_acc_b, (x_fail != 0) ? x_cyc - 1 : NOPS);
    endtask

    initial begin
        vecs[0] = '{en:0, a:0,  bt:0, v:0, e_fail:0, e_cyc:0,   e_elem:0, e_bg:0, e_exp:0,    e_act:0};
        vecs[1] = '{en:1, a:5,  bt:0, v:1, e_fail:1, e_cyc:76,  e_elem:1, e_bg:0, e_exp:'h00, e_act:'h01};
        vecs[2] = '{en:1, a:0,  bt:0, v:0, e_fail:1, e_cyc:194, e_elem:2, e_bg:0, e_exp:'hFF, e_act:'hFE};
        vecs[3] = '{en:1, a:63, bt:7, v:1, e_fail:1, e_cyc:192, e_elem:1, e_bg:0, e_exp:'h00, e_act:'h80};
        for (int i = 0; i < DEPTH; i++) begin ram_a[i] = '0; ram_b[i] = '0; end
        build_ops();

        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs", int'(cs_a), 0);   chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0); chk("rst_fail", int'(fail_a), 0);
        chk("rst_addr", int'(addr_a), 0); chk("rst_wdata", int'(wdata_a), 0);
        rst = 1'b0;

        // Table-driven runs with hand-derived expectations.
        for (int v = 0; v < 4; v++) begin
            f_en = vecs[v].en; f_addr = vecs[v].a; f_bit = vecs[v].bt; f_val = vecs[v].v;
            x_fail = vecs[v].e_fail; x_cyc = vecs[v].e_cyc; x_addr = vecs[v].a;
            x_elem = vecs[v].e_elem; x_bg = vecs[v].e_bg; x_exp = vecs[v].e_exp;
            x_act = vecs[v].e_act;
            run_one(0, v == 0);
            check_run($sformatf("vec%0d", v));
        end

        // Random stuck-at faults checked against the reference model.
        for (int r = 0; r < 4; r++) begin
            f_en = 1; f_addr = int'($urandom_range(0, DEPTH - 1));
            f_bit = int'($urandom_range(0, DW - 1)); f_val = 1'($urandom_range(0, 1));
            predict();
            x_fail = p_fail; x_cyc = p_cyc; x_addr = p_addr; x_elem = p_elem;
            x_bg = p_bg; x_exp = p_exp; x_act = p_act;
            run_one(0, 0);
            check_run($sformatf("rnd%0d", r));
        end

        // start held high: no restart mid-run, restart right after DONE.
        f_en = 1; f_addr = 5; f_bit = 0; f_val = 1;
        run_one(1, 0);
        chk("hold_done_cycle", done_cyc_a, NOPS + 1);
        chk("hold_busy_cycles", busy_cnt, NOPS);
        chk("hold_fail_at_done", int'(fail_a), 1);
        @(posedge clk); #1;
        chk("hold_restart_fail_clr", int'(fail_a), 0);
        chk("hold_restart_done_clr", int'(done_a), 0);
        @(posedge clk); #1;
        chk("hold_restart_busy", int'(busy_a), 1);
        chk("hold_restart_addr", int'(addr_a), 0);
        start = 1'b0;
        rst = 1'b1; @(posedge clk); #1; rst = 1'b0;

        // Reset at cycle 300 aborts the run.
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (299) @(posedge clk);
        #1;
        chk("pre_rst_fail", int'(fail_a), 1);
        chk("pre_rst_busy", int'(busy_a), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_cs", int'(cs_a), 0);     chk("mid_rst_rw", int'(rw_a), 0);
        chk("mid_rst_addr", int'(addr_a), 0); chk("mid_rst_wdata", int'(wdata_a), 0);
        chk("mid_rst_busy", int'(busy_a), 0); chk("mid_rst_done", int'(done_a), 0);
        chk("mid_rst_fail", int'(fail_a), 0); chk("mid_rst_faddr", int'(faddr_a), 0);
        chk("mid_rst_felem", int'(felem_a), 0); chk("mid_rst_fexp", int'(fexp_a), 0);
        chk("mid_rst_fact", int'(fact_a), 0);
        @(posedge clk); #1;
        chk("post_rst_cs_idle", int'(cs_a), 0);
        rst = 1'b0;
        f_en = 0;
        x_fail = 0; x_cyc = 0; x_addr = 0; x_elem = 0; x_bg = 0; x_exp = 0; x_act = 0;
        run_one(0, 0);
        check_run("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
